hier_xbar_one_hot_pipe: RTL

HIER_XBAR_ONE_HOT_PIPE -- requirements
Module: hier_xbar_one_hot_pipe

---
 rtl/hier_xbar_pkg.sv | 17 +
 rtl/xbar_group_mux.sv | 64 ++++++
 rtl/hier_xbar_one_hot_pipe.sv | 137 +++++++++++++
 3 files changed

// File: rtl/hier_xbar_pkg.sv
// Shared constants and helpers for the two-level one-hot crossbar.
package hier_xbar_pkg;

  localparam int unsigned DEF_DATA_WIDTH           = 32;
  localparam int unsigned DEF_NUM_INPUT_DATA       = 16;
  localparam int unsigned DEF_NUM_OUTPUT_DATA      = 8;
  localparam int unsigned DEF_NUM_GROUP            = 2;
  localparam int unsigned DEF_NUM_IN_WIRE_PIPELINE = 5;
  localparam int unsigned ERR_CNT_W                = 16;
  localparam int unsigned MAX_HOT_W                = 64;

  // True when more than one bit is set (clearing the lowest set bit leaves something).
  function automatic logic multi_hot(input logic [MAX_HOT_W-1:0] v);
    return |(v & (v - MAX_HOT_W'(1)));
  endfunction

endpackage

// File: rtl/xbar_group_mux.sv
// Stage-1 group: picks, per output, the single routed input of this group.
module xbar_group_mux
  import hier_xbar_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int unsigned GROUP_SIZE      = DEF_NUM_INPUT_DATA / DEF_NUM_GROUP,
  parameter int unsigned NUM_OUTPUT_DATA = DEF_NUM_OUTPUT_DATA
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  en,
  input  logic [GROUP_SIZE-1:0]                 valid,
  input  logic [GROUP_SIZE*DATA_WIDTH-1:0]      data,
  input  logic [GROUP_SIZE*NUM_OUTPUT_DATA-1:0] cmd,
  output logic [NUM_OUTPUT_DATA-1:0]            grp_valid,
  output logic [NUM_OUTPUT_DATA*DATA_WIDTH-1:0] grp_data,
  output logic [NUM_OUTPUT_DATA-1:0]            grp_err
);

  logic [GROUP_SIZE-1:0]                 sel [NUM_OUTPUT_DATA];
  logic [NUM_OUTPUT_DATA-1:0]            valid_c;
  logic [NUM_OUTPUT_DATA*DATA_WIDTH-1:0] data_c;
  logic [NUM_OUTPUT_DATA-1:0]            err_c;

  // Transpose cmd so each output sees its select column across the group.
  for (genvar i = 0; i < NUM_OUTPUT_DATA; i++) begin : g_out
    for (genvar k = 0; k < GROUP_SIZE; k++) begin : g_in
      assign sel[i][k] = cmd[k*NUM_OUTPUT_DATA + i];
    end
  end

  always_comb begin
    valid_c = '0;
    data_c  = '0;
    err_c   = '0;
    if (en) begin
      for (int i = 0; i < NUM_OUTPUT_DATA; i++) begin
        if (multi_hot(MAX_HOT_W'(sel[i]))) begin
          err_c[i] = 1'b1;
        end else begin
          for (int k = 0; k < GROUP_SIZE; k++) begin
            if (sel[i][k] && valid[k]) begin
              valid_c[i]                        = 1'b1;
              data_c[i*DATA_WIDTH +: DATA_WIDTH] = data[k*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grp_valid <= '0;
      grp_data  <= '0;
      grp_err   <= '0;
    end else begin
      grp_valid <= valid_c;
      grp_data  <= data_c;
      grp_err   <= err_c;
    end
  end

endmodule

// File: rtl/hier_xbar_one_hot_pipe.sv
// Pipelined two-level one-hot crossbar with conflict flags and a saturating error counter.
module hier_xbar_one_hot_pipe
  import hier_xbar_pkg::*;
#(
  parameter int unsigned DATA_WIDTH           = DEF_DATA_WIDTH,
  parameter int unsigned NUM_INPUT_DATA       = DEF_NUM_INPUT_DATA,
  parameter int unsigned NUM_OUTPUT_DATA      = DEF_NUM_OUTPUT_DATA,
  parameter int unsigned NUM_GROUP            = DEF_NUM_GROUP,
  parameter int unsigned NUM_IN_WIRE_PIPELINE = DEF_NUM_IN_WIRE_PIPELINE
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_INPUT_DATA-1:0]             i_valid,
  input  logic [NUM_INPUT_DATA*DATA_WIDTH-1:0]  i_data_bus,
  input  logic                                  i_en,
  input  logic [NUM_INPUT_DATA*NUM_OUTPUT_DATA-1:0] i_cmd,
  output logic [NUM_OUTPUT_DATA-1:0]            o_valid,
  output logic [NUM_OUTPUT_DATA*DATA_WIDTH-1:0] o_data_bus,
  output logic [NUM_OUTPUT_DATA-1:0]            o_cmd_err,
  output logic [ERR_CNT_W-1:0]                  o_err_cnt
);

  localparam int unsigned GS    = NUM_INPUT_DATA / NUM_GROUP;
  localparam int unsigned P     = NUM_IN_WIRE_PIPELINE;
  localparam int unsigned NO    = NUM_OUTPUT_DATA;
  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned CMD_W = NUM_INPUT_DATA * NUM_OUTPUT_DATA;

  if (NUM_GROUP == 0 || (NUM_INPUT_DATA % NUM_GROUP) != 0) begin : g_bad_group
    $error("NUM_INPUT_DATA must be divisible by NUM_GROUP");
  end
  if (P < 1 || NO < 1 || GS > MAX_HOT_W || NUM_GROUP > MAX_HOT_W) begin : g_bad_size
    $error("unsupported crossbar geometry");
  end

  logic [NUM_INPUT_DATA-1:0]    pipe_valid [P];
  logic [NUM_INPUT_DATA*DW-1:0] pipe_data  [P];
  logic [CMD_W-1:0]             pipe_cmd   [P];
  logic                         pipe_en    [P];

  // Input wire pipeline; en rides along with its beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < P; p++) begin
        pipe_valid[p] <= '0;
        pipe_data[p]  <= '0;
        pipe_cmd[p]   <= '0;
        pipe_en[p]    <= 1'b0;
      end
    end else begin
      pipe_valid[0] <= i_valid;
      pipe_data[0]  <= i_data_bus;
      pipe_cmd[0]   <= i_cmd;
      pipe_en[0]    <= i_en;
      for (int p = 1; p < P; p++) begin
        pipe_valid[p] <= pipe_valid[p-1];
        pipe_data[p]  <= pipe_data[p-1];
        pipe_cmd[p]   <= pipe_cmd[p-1];
        pipe_en[p]    <= pipe_en[p-1];
      end
    end
  end

  logic [NUM_GROUP*NO-1:0]    grp_valid;
  logic [NUM_GROUP*NO*DW-1:0] grp_data;
  logic [NUM_GROUP*NO-1:0]    grp_err;

  for (genvar g = 0; g < NUM_GROUP; g++) begin : g_grp
    xbar_group_mux #(
      .DATA_WIDTH      (DW),
      .GROUP_SIZE      (GS),
      .NUM_OUTPUT_DATA (NO)
    ) u_grp (
      .clk       (clk),
      .rst       (rst),
      .en        (pipe_en[P-1]),
      .valid     (pipe_valid[P-1][g*GS +: GS]),
      .data      (pipe_data[P-1][g*GS*DW +: GS*DW]),
      .cmd       (pipe_cmd[P-1][g*GS*NO +: GS*NO]),
      .grp_valid (grp_valid[g*NO +: NO]),
      .grp_data  (grp_data[g*NO*DW +: NO*DW]),
      .grp_err   (grp_err[g*NO +: NO])
    );
  end

  logic [NUM_GROUP-1:0] gv [NO];
  logic [NUM_GROUP-1:0] ge [NO];

  for (genvar i = 0; i < NO; i++) begin : g_col
    for (genvar g = 0; g < NUM_GROUP; g++) begin : g_row
      assign gv[i][g] = grp_valid[g*NO + i];
      assign ge[i][g] = grp_err[g*NO + i];
    end
  end

  logic [NO-1:0]    valid_c;
  logic [NO*DW-1:0] data_c;
  logic [NO-1:0]    err_c;

  // Stage 2: merge groups; two valid groups on one output is a conflict.
  always_comb begin
    valid_c = '0;
    data_c  = '0;
    err_c   = '0;
    for (int i = 0; i < NO; i++) begin
      err_c[i] = |ge[i];
      if (multi_hot(MAX_HOT_W'(gv[i]))) begin
        err_c[i] = 1'b1;
      end else begin
        for (int g = 0; g < NUM_GROUP; g++) begin
          if (gv[i][g]) begin
            valid_c[i]             = 1'b1;
            data_c[i*DW +: DW]     = grp_data[(g*NO + i)*DW +: DW];
          end
        end
      end
    end
  end

  // Counter advances in the same edge that publishes the flagged cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid    <= '0;
      o_data_bus <= '0;
      o_cmd_err  <= '0;
      o_err_cnt  <= '0;
    end else begin
      o_valid    <= valid_c;
      o_data_bus <= data_c;
      o_cmd_err  <= err_c;
      if (|err_c && o_err_cnt != {ERR_CNT_W{1'b1}}) begin
        o_err_cnt <= o_err_cnt + ERR_CNT_W'(1);
      end
    end
  end

endmodule
